// File: rtl/tmr_deserializer.sv
// Serial-to-parallel receiver for repetition-coded frames: majority-votes each
// REP-bit group into a registered data word plus command bit, with abort and correction reporting.
module tmr_deserializer #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned REP       = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_val_i,
  input  logic                 ser_data_i,
  input  logic                 err_clr_i,
  output logic [DATA_W-1:0]    data_o,
  output logic                 command_o,
  output logic                 valid_o,
  output logic                 corr_o,
  output logic                 abort_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned GROUPS    = DATA_W + 1;
  localparam int unsigned FRAME_LEN = GROUPS * REP;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned SHIFT_W   = FRAME_LEN - 1;
  localparam int unsigned ONES_W    = $clog2(REP + 1);

  if ((REP % 2) == 0 || DATA_W < 1) begin : g_param_check
    $error("tmr_deserializer: REP must be odd and >=1, DATA_W must be >=1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   cmd_q, cmd_d;
  logic                   valid_q, valid_d;
  logic                   corr_q, corr_d;
  logic                   abort_q, abort_d;
  logic                   busy_q, busy_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [FRAME_LEN-1:0]   frame_c;
  logic [GROUPS-1:0]      voted_c;
  logic                   corr_c;
  logic                   done_c;
  logic [ONES_W-1:0]      ones_c;

  // Full frame as seen on the last bit: earlier bits in the shift register, final bit live.
  assign frame_c = {shift_q, ser_data_i};

  // Majority vote per group; group 0 lands in the MSB of the voted word.
  always_comb begin
    voted_c = '0;
    corr_c  = 1'b0;
    ones_c  = '0;
    for (int g = 0; g < int'(GROUPS); g++) begin
      ones_c = '0;
      for (int r = 0; r < int'(REP); r++) begin
        ones_c = ones_c + ONES_W'(frame_c[int'(FRAME_LEN) - 1 - g * int'(REP) - r]);
      end
      voted_c[int'(GROUPS) - 1 - g] = (ones_c > ONES_W'(REP / 2));
      if (ones_c != '0 && ones_c != ONES_W'(REP)) begin
        corr_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    cmd_d     = cmd_q;
    corr_d    = corr_q;
    valid_d   = 1'b0;
    abort_d   = 1'b0;
    done_c    = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (data_val_i) begin
          shift_d = SHIFT_W'(ser_data_i);
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (!data_val_i) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
          done_c  = 1'b1;
          data_d  = voted_c[GROUPS-1:1];
          cmd_d   = voted_c[0];
          corr_d  = corr_c;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          shift_d = SHIFT_W'({shift_q, ser_data_i});
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over the old count but not over an increment in the same cycle.
    if (err_clr_i) begin
      err_cnt_d = (done_c && corr_c) ? ERR_CNT_W'(1) : '0;
    end else if (done_c && corr_c && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      cmd_q     <= 1'b0;
      valid_q   <= 1'b0;
      corr_q    <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      corr_q    <= corr_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data_o    = data_q;
  assign command_o = cmd_q;
  assign valid_o   = valid_q;
  assign corr_o    = corr_q;
  assign abort_o   = abort_q;
  assign busy_o    = busy_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_tmr_deserializer.sv
// Directed bench for tmr_deserializer: two instances (8-bit and 2-bit error counters) share one stimulus.
module tb_tmr_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, data_val, ser_data, err_clr;
  logic [4:0] data_a, data_b;
  logic cmd_a, valid_a, corr_a, abort_a, busy_a;
  logic cmd_b, valid_b, corr_b, abort_b, busy_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // Hand-encoded frames, first group in the MSBs.
  localparam logic [17:0] F1 = 18'b111_000_111_111_000_111; // 10110 cmd 1 clean
  localparam logic [17:0] F2 = 18'b110_000_111_111_000_011; // 10110 cmd 1 corrected
  localparam logic [17:0] FA = 18'b000_111_000_000_111_000; // 01001 cmd 0 clean
  localparam logic [17:0] FB = 18'b111_111_101_000_000_111; // 11100 cmd 1 corrected
  localparam logic [17:0] FZ = 18'b000_000_000_000_000_000;

  tmr_deserializer #(.DATA_W(5), .REP(3), .ERR_CNT_W(8)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .data_val_i(data_val), .ser_data_i(ser_data),
    .err_clr_i(err_clr), .data_o(data_a), .command_o(cmd_a), .valid_o(valid_a),
    .corr_o(corr_a), .abort_o(abort_a), .busy_o(busy_a), .err_cnt_o(cnt_a)
  );

  tmr_deserializer #(.DATA_W(5), .REP(3), .ERR_CNT_W(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .data_val_i(data_val), .ser_data_i(ser_data),
    .err_clr_i(err_clr), .data_o(data_b), .command_o(cmd_b), .valid_o(valid_b),
    .corr_o(corr_b), .abort_o(abort_b), .busy_o(busy_b), .err_cnt_o(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_val = 1'b0;
    repeat (n) tick();
  endtask

  // Drives one full frame; on return the cycle with valid_o is current and is checked.
  task automatic send_frame(input logic [17:0] bits, input logic clr_last,
                            input logic [4:0] exp_data, input logic exp_cmd,
                            input logic exp_corr, input int exp_ca, input int exp_cb);
    for (int i = 0; i < 18; i++) begin
      data_val = 1'b1;
      ser_data = bits[17-i];
      err_clr  = clr_last && (i == 17);
      tick();
      if (i == 0) check_eq("busy_start", 32'(busy_a), 32'd1);
      if (i > 0 && i < 17) check_eq("no_early_valid", 32'(valid_a), 32'd0);
    end
    err_clr = 1'b0;
    check_eq("valid_a", 32'(valid_a), 32'd1);
    check_eq("valid_b", 32'(valid_b), 32'd1);
    check_eq("data_a", 32'(data_a), 32'(exp_data));
    check_eq("data_b", 32'(data_b), 32'(exp_data));
    check_eq("cmd", 32'(cmd_a), 32'(exp_cmd));
    check_eq("corr", 32'(corr_a), 32'(exp_corr));
    check_eq("busy_done", 32'(busy_a), 32'd0);
    check_eq("err_cnt_a", 32'(cnt_a), 32'(exp_ca));
    check_eq("err_cnt_b", 32'(cnt_b), 32'(exp_cb));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, 32'(data_a), 32'd0);
    check_eq({tag, "_cmd"}, 32'(cmd_a), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid_a), 32'd0);
    check_eq({tag, "_corr"}, 32'(corr_a), 32'd0);
    check_eq({tag, "_abort"}, 32'(abort_a), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
    check_eq({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    data_val = 1'b0;
    ser_data = 1'b0;
    err_clr  = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Clean frame, then outputs hold with strobe dropped.
    send_frame(F1, 1'b0, 5'b10110, 1'b1, 1'b0, 0, 0);
    idle(1);
    check_eq("valid_drop", 32'(valid_a), 32'd0);
    check_eq("data_hold", 32'(data_a), 32'h16);

    // Single-bit errors in first and command groups get corrected.
    send_frame(F2, 1'b0, 5'b10110, 1'b1, 1'b1, 1, 1);
    idle(1);

    // Abort: data_val_i low at cycle 9.
    for (int i = 0; i < 9; i++) begin
      data_val = 1'b1;
      ser_data = FZ[17-i];
      tick();
    end
    check_eq("busy_mid", 32'(busy_a), 32'd1);
    data_val = 1'b0;
    tick();
    check_eq("abort_pulse", 32'(abort_a), 32'd1);
    check_eq("abort_no_valid", 32'(valid_a), 32'd0);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_data_hold", 32'(data_a), 32'h16);
    check_eq("abort_corr_hold", 32'(corr_a), 32'd1);
    tick();
    check_eq("abort_drop", 32'(abort_a), 32'd0);

    // Zero-gap back-to-back frames.
    send_frame(FA, 1'b0, 5'b01001, 1'b0, 1'b0, 1, 1);
    send_frame(FB, 1'b0, 5'b11100, 1'b1, 1'b1, 2, 2);
    idle(1);

    // Clear alone, then saturation of the 2-bit counter.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("clr_a", 32'(cnt_a), 32'd0);
    check_eq("clr_b", 32'(cnt_b), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      send_frame(FB, 1'b0, 5'b11100, 1'b1, 1'b1, k, (k > 3) ? 3 : k);
    end
    send_frame(FB, 1'b1, 5'b11100, 1'b1, 1'b1, 1, 1);
    idle(2);

    // Asynchronous reset mid-frame, then normal decode.
    for (int i = 0; i < 7; i++) begin
      data_val = 1'b1;
      ser_data = F1[17-i];
      tick();
    end
    rst_n    = 1'b0;
    data_val = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) tick();
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    idle(1);
    send_frame(FB, 1'b0, 5'b11100, 1'b1, 1'b1, 1, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
